// File: rtl/rv151_pkg.sv
// rv151_pkg: UART MMIO offsets, byte type and receive-queue default depth
// shared across the rv151 SoC.
package rv151_pkg;
   localparam logic [7:0] UART_STAT_OFS = 8'h00;
   localparam logic [7:0] UART_RXD_OFS  = 8'h04;
   localparam logic [7:0] UART_TXD_OFS  = 8'h08;
   localparam int RXQ_DEPTH = 16;
   typedef logic [7:0] byte_t;
endpackage

// File: rtl/rv151_fifo_ram.sv
// rv151_fifo_ram: DEPTH x 8 flop array, one write port and one asynchronous
// read port; contents are intentionally not reset.
module rv151_fifo_ram
   import rv151_pkg::*;
#(
   parameter int DEPTH = RXQ_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  byte_t         wdata,
   input  logic [AW-1:0] raddr,
   output byte_t         rdata
);
   byte_t mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/rv151_uart_rxq.sv
// rv151_uart_rxq: first-word-fall-through receive byte queue with sticky overflow.
// Define RV151_RXQ_DROPCNT_EN to add the 16-bit saturating drop counter.
module rv151_uart_rxq
   import rv151_pkg::*;
#(
   parameter int DEPTH = RXQ_DEPTH,
   localparam int CW = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  byte_t         rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   input  logic          pop,
   input  logic          flush,
   input  logic          ovf_clr,
   output byte_t         q_data,
   output logic          q_valid,
   output logic [CW-1:0] q_count,
   output logic          q_ovf,
   output logic [15:0]   q_drops
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic ovf_q, ovf_d, rdy_q;
   logic empty, full, do_push, do_pop, drop, wr_en;
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      empty   = head_q == tail_q;
      full    = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
      do_pop  = pop && !empty;
      do_push = rx_valid && rdy_q && (!full || do_pop);
      drop    = rx_valid && rdy_q && full && !do_pop && !flush;
      wr_en   = do_push && !flush;
      head_d  = flush ? '0 : head_q + (AW+1)'(do_pop);
      tail_d  = flush ? '0 : tail_q + (AW+1)'(do_push);
      count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
      ovf_d   = drop || (ovf_q && !ovf_clr);
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         rdy_q   <= 1'b1;
      end
   end
`ifdef RV151_RXQ_DROPCNT_EN
   logic [15:0] drops_q, drops_d;
   // A drop coinciding with a clear restarts the count at one.
   always_comb
      drops_d = drop ? (ovf_clr ? 16'd1 : (&drops_q ? drops_q : drops_q + 16'd1))
                     : (ovf_clr ? 16'd0 : drops_q);
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) drops_q <= '0;
      else drops_q <= drops_d;
   assign q_drops = drops_q;
`else
   assign q_drops = 16'h0;
`endif
   rv151_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .clk  (clk),
      .we   (wr_en),
      .waddr(tail_q[AW-1:0]),
      .wdata(rx_data),
      .raddr(head_q[AW-1:0]),
      .rdata(q_data)
   );
   assign rx_ready = rdy_q;
   assign q_valid  = !empty;
   assign q_count  = count_q;
   assign q_ovf    = ovf_q;
endmodule

// File: tb/tb_rv151_uart_rxq.sv
// tb_rv151_uart_rxq: randomized bench for the receive queue against a
// queue-based behavioural model.
module tb_rv151_uart_rxq;
   import rv151_pkg::*;
   localparam int DEPTH = 16;
   localparam int CW = $clog2(DEPTH+1);
   logic clk = 1'b0, rstn = 1'b0;
   byte_t rx_data = '0, q_data;
   logic rx_valid = 1'b0, rx_ready, pop = 1'b0, flush = 1'b0, ovf_clr = 1'b0;
   logic q_valid, q_ovf;
   logic [CW-1:0] q_count;
   logic [15:0] q_drops;
   int n_checks = 0, n_errors = 0;
   byte_t mq[$];
   logic m_ovf = 1'b0, m_rdy = 1'b0;
   int m_drops = 0;
   rv151_uart_rxq #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .pop(pop), .flush(flush), .ovf_clr(ovf_clr), .q_data(q_data), .q_valid(q_valid),
      .q_count(q_count), .q_ovf(q_ovf), .q_drops(q_drops)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_outputs();
      chk("rx_ready", 32'(rx_ready), 32'(m_rdy));
      chk("q_valid", 32'(q_valid), 32'(mq.size() != 0));
      chk("q_count", 32'(q_count), mq.size());
      if (mq.size() != 0) chk("q_data", 32'(q_data), 32'(mq[0]));
      chk("q_ovf", 32'(q_ovf), 32'(m_ovf));
      chk("q_drops", 32'(q_drops), m_drops);
   endtask
   // Drive one cycle, check the pre-edge state, then advance the model.
   task automatic cycle(input logic v, input byte_t d, input logic p, input logic f, input logic c);
      logic dropped;
      rx_valid = v; rx_data = d; pop = p; flush = f; ovf_clr = c;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      dropped = 1'b0;
      if (!f) begin
         if (p && mq.size() > 0) void'(mq.pop_front());
         if (v && m_rdy) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else dropped = 1'b1;
         end
      end else mq.delete();
      if (dropped) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
`ifdef RV151_RXQ_DROPCNT_EN
      if (dropped) m_drops = c ? 1 : (m_drops == 65535 ? m_drops : m_drops + 1);
      else if (c) m_drops = 0;
`endif
      m_rdy = 1'b1;
      #1;
   endtask
   task automatic check_reset();
      chk("rst_q_valid", 32'(q_valid), 0);
      chk("rst_q_count", 32'(q_count), 0);
      chk("rst_q_ovf", 32'(q_ovf), 0);
      chk("rst_q_drops", 32'(q_drops), 0);
      chk("rst_rx_ready", 32'(rx_ready), 0);
      mq.delete(); m_ovf = 1'b0; m_drops = 0; m_rdy = 1'b0;
   endtask
   // Assert reset between edges and verify outputs clear before the next edge.
   task automatic reset_mid();
      #2 rstn = 1'b0;
      rx_valid = 1'b0; pop = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
      #1 check_reset();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset();
      rstn = 1'b1;
      cycle(0, 8'h00, 0, 0, 0);
      cycle(1, 8'hA5, 0, 0, 0);
      chk("single_data", 32'(q_data), 32'hA5);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      for (int i = 0; i <= DEPTH; i++) cycle(1, 8'(i), 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);
      chk("fill_ovf", 32'(q_ovf), 1);
      cycle(1, 8'h55, 1, 0, 0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 40; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
      cycle(1, 8'h77, 0, 0, 0);
      cycle(1, 8'h99, 0, 1, 0);
      cycle(0, 8'h00, 0, 0, 0);
      chk("flush_count", 32'(q_count), 0);
      for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0, 0, 0);
      cycle(1, 8'hEE, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0);
      chk("clr_vs_set", 32'(q_ovf), 1);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 20) == 0));
      cycle(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 5; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0);
      chk("pre_reset_count", 32'(q_count), 5);
      reset_mid();
      for (int i = 0; i < 30; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
